// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC and fetches one instruction at a time.
// It presents each word to decode and holds it until execute retires it.
// At retirement it picks the next PC from the resolved flow-control inputs.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        Jump,
    input  logic        Jal,
    input  logic        Jr,
    input  logic        Branch,
    input  logic        NEqual,
    input  logic        alu_zero,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic [31:0] retired
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        take_jump;
    logic        take_branch;

    assign pc4       = pc + 32'd4;
    assign link_addr = pc4;
    assign imem_addr = pc;

    // Jal is always decoded together with Jump; OR-ing it in keeps a lone
    // Jal from silently falling through to pc4.
    assign take_jump   = Jump | Jal;
    assign take_branch = Branch & (alu_zero ^ NEqual);
    assign br_off      = {{14{instr[15]}}, instr[15:0], 2'b00};

    // Next-PC selection, Jr highest priority, sequential lowest.
    always_comb begin
        next_pc = pc4;
        if (Jr)
            next_pc = jr_target & ~32'h0000_0003;
        else if (take_jump)
            next_pc = {pc4[31:28], instr[25:0], 2'b00};
        else if (take_branch)
            next_pc = pc4 + br_off;
    end

    // Fetch sequencer: IDLE -> REQ (wait for ack) -> HOLD (wait for retire).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            retired     <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc          <= next_pc;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        retired     <= retired + 32'd1;
                        state       <= S_REQ;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, wait states,
// a table of flow-control vectors, and async reset during a fetch.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        Jump = 1'b0, Jal = 1'b0, Jr = 1'b0;
    logic        Branch = 1'b0, NEqual = 1'b0, alu_zero = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_retired = 32'h0;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Jump(Jump), .Jal(Jal), .Jr(Jr), .Branch(Branch), .NEqual(NEqual),
        .alu_zero(alu_zero), .jr_target(jr_target),
        .pc(pc), .link_addr(link_addr), .retired(retired)
    );

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] word;
        logic        jump, jal, jr, br, neq, zero;
        logic [31:0] jr_t;
        logic [31:0] exp_pc;
        logic [31:0] exp_link;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bounded wait for the fetch request; a timeout counts as a failure.
    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_timeout", {31'b0, imem_req}, 32'h1);
    endtask

    // Fetch one word after `delay` unacked cycles; optionally pulse ready
    // during the first wait cycle, which must be ignored.
    task automatic do_fetch(input logic [31:0] word, input int delay, input bit ready_pulse);
        logic [31:0] a0;
        wait_req();
        a0 = imem_addr;
        chk("addr_eq_pc", imem_addr, pc);
        for (int d = 0; d < delay; d++) begin
            imem_ack    = 1'b0;
            imem_rdata  = 32'hBAD0_0000 | d;
            instr_ready = ready_pulse && d == 0;
            @(negedge clk);
            instr_ready = 1'b0;
            chk("wait_req", {31'b0, imem_req}, 32'h1);
            chk("wait_addr", imem_addr, a0);
            chk("wait_pc", pc, a0);
            chk("wait_valid", {31'b0, instr_valid}, 32'h0);
            chk("wait_retired", retired, exp_retired);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        chk("cap_instr", instr, word);
        chk("cap_valid", {31'b0, instr_valid}, 32'h1);
        chk("cap_req", {31'b0, imem_req}, 32'h0);
    endtask

    task automatic do_retire(input logic jp, input logic jl, input logic jrr,
                             input logic br, input logic neq, input logic z,
                             input logic [31:0] jt);
        Jump = jp; Jal = jl; Jr = jrr; Branch = br; NEqual = neq; alu_zero = z;
        jr_target = jt;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        {Jump, Jal, Jr, Branch, NEqual, alu_zero} = 6'b0;
        jr_target = 32'h0;
        exp_retired = exp_retired + 32'd1;
        chk("ret_count", retired, exp_retired);
        chk("ret_valid", {31'b0, instr_valid}, 32'h0);
        chk("ret_req", {31'b0, imem_req}, 32'h1);
    endtask

    initial begin
        //             start_pc       word           jp  jl  jr  br  neq z   jr_t           exp_pc         exp_link
        vecs[0] = '{32'h0000_0100, 32'h0000_FFFE, 0, 0, 0, 1, 0, 1, 32'h0,         32'h0000_00FC, 32'h0000_0104};
        vecs[1] = '{32'h0000_0100, 32'h0000_FFFE, 0, 0, 0, 1, 0, 0, 32'h0,         32'h0000_0104, 32'h0000_0104};
        vecs[2] = '{32'h0000_0100, 32'h0000_FFFE, 0, 0, 0, 1, 1, 0, 32'h0,         32'h0000_00FC, 32'h0000_0104};
        vecs[3] = '{32'h1000_0040, 32'h0800_0123, 1, 0, 0, 0, 0, 0, 32'h0,         32'h1000_048C, 32'h1000_0044};
        vecs[4] = '{32'h1000_0040, 32'h0C00_0123, 1, 1, 0, 0, 0, 0, 32'h0,         32'h1000_048C, 32'h1000_0044};
        vecs[5] = '{32'h1000_0040, 32'h03E0_0008, 0, 0, 1, 0, 0, 0, 32'h0000_2003, 32'h0000_2000, 32'h1000_0044};
        vecs[6] = '{32'h0000_0100, 32'h0000_FFFE, 1, 0, 1, 1, 0, 1, 32'h0000_3001, 32'h0000_3000, 32'h0000_0104};
        vecs[7] = '{32'hFFFF_FFF0, 32'h0000_0004, 0, 0, 0, 1, 0, 1, 32'h0,         32'h0000_0004, 32'hFFFF_FFF4};
        vecs[8] = '{32'h0000_0200, 32'h0000_0010, 0, 0, 0, 1, 1, 1, 32'h0,         32'h0000_0204, 32'h0000_0204};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_retired", retired, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle2req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", {31'b0, instr_valid}, 32'h0);

        // Sequential fetch with a 3-cycle wait and an ignored ready pulse at 0x4
        do_fetch(32'h1111_0000, 0, 1'b0);
        chk("link0", link_addr, 32'h4);
        do_retire(0, 0, 0, 0, 0, 0, 32'h0);
        chk("seq_pc4", pc, 32'h4);
        do_fetch(32'h2222_0000, 3, 1'b1);
        chk("link4", link_addr, 32'h8);
        do_retire(0, 0, 0, 0, 0, 0, 32'h0);
        chk("seq_pc8", pc, 32'h8);
        do_fetch(32'h3333_0000, 0, 1'b0);
        do_retire(0, 0, 0, 0, 0, 0, 32'h0);
        chk("seq_pcC", pc, 32'hC);
        do_fetch(32'h0, 0, 1'b0);

        // Table of flow-control vectors; Jr steers to each start pc first
        for (int i = 0; i < 9; i++) begin
            do_retire(0, 0, 1, 0, 0, 0, vecs[i].start_pc);
            chk("vec_start", pc, vecs[i].start_pc);
            do_fetch(vecs[i].word, 0, 1'b0);
            chk("vec_link", link_addr, vecs[i].exp_link);
            do_retire(vecs[i].jump, vecs[i].jal, vecs[i].jr, vecs[i].br,
                      vecs[i].neq, vecs[i].zero, vecs[i].jr_t);
            if (pc !== vecs[i].exp_pc)
                $display("  vector %0d next pc", i);
            chk("vec_next_pc", pc, vecs[i].exp_pc);
            do_fetch(32'h0, 0, 1'b0);
        end

        // Async reset in the middle of a REQ wait with ack in the same cycle
        do_retire(0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        #2;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        rst        = 1'b1;
        #1;
        chk("arst_req", {31'b0, imem_req}, 32'h0);
        chk("arst_pc", pc, 32'h0);
        chk("arst_valid", {31'b0, instr_valid}, 32'h0);
        chk("arst_retired", retired, 32'h0);
        chk("arst_instr", instr, 32'h0);
        @(negedge clk);
        chk("arst_hold_instr", instr, 32'h0);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        rst        = 1'b0;
        exp_retired = 32'h0;
        #1;
        chk("arst_idle_req", {31'b0, imem_req}, 32'h0);
        @(negedge clk);
        chk("arst_restart_req", {31'b0, imem_req}, 32'h1);
        chk("arst_restart_pc", pc, 32'h0);
        do_fetch(32'h4444_0000, 0, 1'b0);
        do_retire(0, 0, 0, 0, 0, 0, 32'h0);
        chk("arst_after_pc", pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
